// File: rtl/fetch_unit_if.sv
// Instruction-cache request/response bundle between the fetch unit (master)
// and the instruction cache (slave).
interface fetch_unit_if;
  logic [29:0] icache_addr;
  logic        icache_re;
  logic        icache_ready;
  logic [31:0] icache_dout;
  logic        icache_valid;

  modport master (
    output icache_addr,
    output icache_re,
    input  icache_ready,
    input  icache_dout,
    input  icache_valid
  );

  modport slave (
    input  icache_addr,
    input  icache_re,
    output icache_ready,
    output icache_dout,
    output icache_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch unit: issues one instruction-cache read per PC value, squashes
// responses made stale by a redirect, and holds the delivered instruction
// while decode is stalled.
// Optional feature: define FETCH_MISALIGN_CHECK_EN to add the sticky
// Misaligned output (set when a request with PC_In[1:0] != 0 is accepted).
//
// state | meaning
// IDLE  | first cycle out of reset, nothing issued yet
// REQ   | read request presented, address follows PC_In
// WAIT  | request accepted, waiting for the response
// KILL  | redirect seen while waiting, response will be dropped
// HOLD  | instruction delivered, decode stalled, output held
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_In,
  input  logic        redirect,
  input  logic        stall_in,
  fetch_unit_if.master ic,
  output logic [31:0] Inst_Out,
  output logic        Inst_Valid,
  output logic        fetch_stall
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        Misaligned
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    KILL = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        req_accept;

  // Request is gated by reset so nothing is issued while reset is held,
  // even before the first clock edge has forced the state to IDLE.
  assign ic.icache_re   = (state_q == REQ) && !reset;
  assign ic.icache_addr = PC_In[31:2];
  assign req_accept     = ic.icache_re && ic.icache_ready;
  assign fetch_stall    = !req_accept;
  assign Inst_Out       = inst_q;
  assign Inst_Valid     = valid_q;

  // Next-state and instruction register update; Inst_Valid defaults to 0 so
  // it only survives a load or an uninterrupted hold.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (ic.icache_ready) state_d = WAIT;
      end
      WAIT: begin
        if (ic.icache_valid && !redirect) begin
          inst_d  = ic.icache_dout;
          valid_d = 1'b1;
          state_d = stall_in ? HOLD : REQ;
        end else if (ic.icache_valid) begin
          state_d = REQ;
        end else if (redirect) begin
          state_d = KILL;
        end
      end
      KILL: begin
        if (ic.icache_valid) state_d = REQ;
      end
      HOLD: begin
        if (redirect || !stall_in) begin
          state_d = REQ;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous reset to IDLE with a NOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q, mis_d;

  assign mis_d      = mis_q | (req_accept && (PC_In[1:0] != 2'b00));
  assign Misaligned = mis_q;

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end
`else
  logic pc_lo_unused;
  assign pc_lo_unused = ^PC_In[1:0];
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model of the fetch unit.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_In;
  logic        redirect;
  logic        stall_in;
  logic [31:0] Inst_Out;
  logic        Inst_Valid;
  logic        fetch_stall;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        Misaligned;
`endif

  fetch_unit_if ic();

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .PC_In       (PC_In),
    .redirect    (redirect),
    .stall_in    (stall_in),
    .ic          (ic),
    .Inst_Out    (Inst_Out),
    .Inst_Valid  (Inst_Valid),
    .fetch_stall (fetch_stall)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .Misaligned  (Misaligned)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: "boot" = first cycle after reset, "flight" = a request was
  // accepted and its response is outstanding, "stale" = that response must
  // be dropped, "hold" = a delivered instruction is parked for decode.
  bit          m_boot   = 1'b1;
  bit          m_flight = 1'b0;
  bit          m_stale  = 1'b0;
  bit          m_hold   = 1'b0;
  logic [31:0] m_inst   = NOP;
  bit          m_vld    = 1'b0;
  bit          m_mis    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] pc, input logic rdy,
                       input logic rd, input logic stl, input logic v,
                       input logic [31:0] d);
    reset           = r;
    PC_In           = pc;
    ic.icache_ready = rdy;
    redirect        = rd;
    stall_in        = stl;
    ic.icache_valid = v;
    ic.icache_dout  = d;
  endtask

  task automatic model_edge();
    bit nv;
    if (reset) begin
      m_boot = 1'b1; m_flight = 1'b0; m_stale = 1'b0; m_hold = 1'b0;
      m_inst = NOP;  m_vld = 1'b0;    m_mis = 1'b0;
    end else begin
      nv = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_hold) begin
        if (!redirect && stall_in) nv = 1'b1;
        else m_hold = 1'b0;
      end else if (m_flight) begin
        if (ic.icache_valid) begin
          m_flight = 1'b0;
          if (!m_stale && !redirect) begin
            m_inst = ic.icache_dout;
            nv     = 1'b1;
            m_hold = stall_in;
          end
        end else if (redirect) begin
          m_stale = 1'b1;
        end
      end else if (ic.icache_ready) begin
        m_flight = 1'b1;
        m_stale  = 1'b0;
        if (PC_In[1:0] != 2'b00) m_mis = 1'b1;
      end
      m_vld = nv;
    end
  endtask

  // One clock: combinational checks mid-cycle, registered checks after the edge.
  task automatic cyc();
    logic exp_re;
    @(negedge clk);
    exp_re = !reset && !m_boot && !m_flight && !m_hold;
    chk("icache_re", {31'b0, ic.icache_re}, {31'b0, exp_re});
    chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, !(exp_re && ic.icache_ready)});
    if (exp_re) chk("icache_addr", {2'b0, ic.icache_addr}, PC_In >> 2);
    @(posedge clk);
    model_edge();
    #1;
    chk("Inst_Out", Inst_Out, m_inst);
    chk("Inst_Valid", {31'b0, Inst_Valid}, {31'b0, m_vld});
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("Misaligned", {31'b0, Misaligned}, {31'b0, m_mis});
`endif
  endtask

  initial begin
    logic [31:0] pc;
    // reset state
    drive(1, 32'h2000, 1, 0, 0, 0, 32'h0);
    cyc(); cyc();
    chk("rst_inst", Inst_Out, NOP);
    chk("rst_re", {31'b0, ic.icache_re}, 32'h0);

    // basic fetch of 0x2000, response two cycles after acceptance
    drive(0, 32'h2000, 1, 0, 0, 0, 32'h0);
    cyc();
    #1 chk("addr_800", {2'b0, ic.icache_addr}, 32'h800);
    cyc();
    drive(0, 32'h2004, 0, 0, 0, 0, 32'h0);
    cyc();
    drive(0, 32'h2004, 0, 0, 0, 1, 32'h0050_0093);
    cyc();
    chk("inst_first", Inst_Out, 32'h0050_0093);
    chk("vld_first", {31'b0, Inst_Valid}, 32'h1);

    // cache not ready for 3 cycles, then accepted
    drive(0, 32'h2004, 0, 0, 0, 0, 32'h0);
    repeat (3) cyc();
    chk("vld_pulse_end", {31'b0, Inst_Valid}, 32'h0);
    drive(0, 32'h2004, 1, 0, 0, 0, 32'h0);
    cyc();

    // redirect while waiting, late response dropped, new PC fetched
    drive(0, 32'h3000, 0, 1, 0, 0, 32'h0);
    cyc();
    drive(0, 32'h3000, 0, 0, 0, 0, 32'h0);
    cyc();
    drive(0, 32'h3000, 0, 1, 0, 0, 32'h0);
    cyc();
    drive(0, 32'h3000, 0, 0, 0, 1, 32'hDEAD_BEEF);
    cyc();
    chk("inst_kept", Inst_Out, 32'h0050_0093);
    chk("vld_killed", {31'b0, Inst_Valid}, 32'h0);
    drive(0, 32'h3000, 1, 0, 0, 0, 32'h0);
    #1 chk("addr_c00", {2'b0, ic.icache_addr}, 32'hC00);
    cyc();

    // redirect together with response: drop, straight back to requesting
    drive(0, 32'h3004, 0, 1, 0, 1, 32'h1111_1111);
    cyc();
    chk("re_after_drop", {31'b0, ic.icache_re}, 32'h1);
    chk("inst_drop", Inst_Out, 32'h0050_0093);

    // stall at delivery for 4 cycles
    drive(0, 32'h3004, 1, 0, 0, 0, 32'h0);
    cyc();
    drive(0, 32'h3008, 0, 0, 1, 1, 32'h2222_2222);
    cyc();
    drive(0, 32'h3008, 0, 0, 1, 0, 32'h0);
    repeat (3) cyc();
    chk("hold_inst", Inst_Out, 32'h2222_2222);
    drive(0, 32'h3008, 0, 0, 0, 1, 32'h9999_9999);
    cyc();
    chk("re_after_hold", {31'b0, ic.icache_re}, 32'h1);

    // redirect while holding
    drive(0, 32'h3008, 1, 0, 0, 0, 32'h0);
    cyc();
    drive(0, 32'h3008, 0, 0, 1, 1, 32'h3333_3333);
    cyc();
    drive(0, 32'h4000, 0, 1, 1, 0, 32'h0);
    cyc();
    chk("hold_redirect_vld", {31'b0, Inst_Valid}, 32'h0);

    // reset mid-fetch, stale response ignored
    drive(0, 32'h4000, 1, 0, 0, 0, 32'h0);
    cyc();
    drive(1, 32'h4000, 0, 0, 0, 0, 32'h0);
    cyc();
    drive(0, 32'h4000, 0, 0, 0, 1, 32'h0BAD_0BAD);
    cyc();
    chk("rst_mid_inst", Inst_Out, NOP);
    chk("rst_mid_vld", {31'b0, Inst_Valid}, 32'h0);

    // misaligned request accepted
    drive(0, 32'h2002, 1, 0, 0, 0, 32'h0);
    cyc();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misaligned_set", {31'b0, Misaligned}, 32'h1);
`endif
    drive(0, 32'h2008, 0, 0, 0, 1, 32'h4444_4444);
    cyc();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      pc = $urandom;
      if ($urandom_range(7) != 0) pc[1:0] = 2'b00;
      drive(($urandom_range(63) == 0), pc, 1'($urandom_range(1)),
            ($urandom_range(4) == 0), ($urandom_range(2) == 0),
            ($urandom_range(2) == 0), $urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
- REQ-001: clk  input  1  single clock; all state updates on posedge clk.
- REQ-002: reset  input  1  reset is synchronous and active-high.
- REQ-003: PC_In  input  32  current fetch address from the PC register.
- REQ-004: redirect  input  1  taken branch/jump this cycle (the PC_Sel event); any in-flight fetch is stale.
- REQ-005: stall_in  input  1  downstream pipeline stall; hold the delivered instruction.
- REQ-006: icache_addr  output  30  word address, equal to PC_In[31:2].
- REQ-007: icache_re  output  1  read request to the instruction cache.
- REQ-008: icache_ready  input  1  cache accepts the request this cycle.
- REQ-009: icache_dout  input  32  instruction data returned by the cache.
- REQ-010: icache_valid  input  1  icache_dout is valid this cycle.
- REQ-011: Inst_Out  output  32  registered instruction to decode.
- REQ-012: Inst_Valid  output  1  Inst_Out holds a live, non-squashed instruction.
- REQ-013: fetch_stall  output  1  PC register hold request, combinational.

Function
- REQ-014: The FSM SHALL have exactly five states: IDLE, REQ, WAIT, KILL and HOLD.
- REQ-015: IDLE SHALL move to REQ unconditionally on the first cycle after reset deasserts.
- REQ-016: In REQ, icache_re SHALL be 1 and icache_addr SHALL be PC_In[31:2] (combinational).
- REQ-017: In REQ, icache_ready=1 SHALL cause a move to WAIT; otherwise the FSM SHALL stay in REQ.
- REQ-018: In REQ, redirect SHALL need no action, because the address tracks PC_In.
- REQ-019: fetch_stall SHALL equal NOT(state==REQ AND icache_ready), so the PC advances exactly once per accepted request.
- REQ-020: In WAIT, KILL and HOLD, icache_re SHALL be 0.
- REQ-021: In WAIT, icache_valid=1 with redirect=0 SHALL load icache_dout into Inst_Out and set Inst_Valid=1 on the next edge.
- REQ-022: After a REQ-021 load, the FSM SHALL go to HOLD if stall_in=1, otherwise to REQ.
- REQ-023: In WAIT, redirect=1 without icache_valid SHALL move the FSM to KILL.
- REQ-024: In WAIT, redirect=1 in the same cycle as icache_valid=1 SHALL discard the data, leave Inst_Out unchanged, and move the FSM to REQ.
- REQ-025: In KILL, icache_valid=1 SHALL discard the data and move the FSM to REQ; otherwise the FSM SHALL stay in KILL, and a repeated redirect has no further effect.
- REQ-026: Inst_Valid SHALL be 0 in every cycle not covered by REQ-021 or REQ-027, i.e. a one-cycle pulse per delivered instruction when stall_in=0.
- REQ-027: In HOLD, Inst_Out and Inst_Valid=1 SHALL be held; stall_in=0 SHALL move the FSM to REQ.
- REQ-028: redirect=1 in HOLD SHALL clear Inst_Valid to 0 on the next edge and move the FSM to REQ.
- REQ-029: icache_valid arriving outside WAIT/KILL SHALL be ignored.
- REQ-030: PC_In[1:0] SHALL be ignored for addressing.

Reset
- REQ-031: While reset=1, the FSM SHALL be in IDLE, Inst_Out SHALL be 32'h00000013 (NOP), Inst_Valid SHALL be 0, and icache_re SHALL be 0.
- REQ-032: Reset asserted mid-fetch (WAIT/KILL) SHALL abandon the fetch; the late response SHALL be ignored per REQ-029.
- REQ-033: Reset SHALL override every other input in the same cycle.

Configuration
- REQ-034: With FETCH_MISALIGN_CHECK_EN defined, the block SHALL add output Misaligned (1 bit), set sticky when a request is accepted with PC_In[1:0]!=0 and cleared only by reset.
- REQ-035: With FETCH_MISALIGN_CHECK_EN undefined, the Misaligned port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-036: Reset, PC_In=0x2000, icache_ready=1, response 0x00500093 two cycles after acceptance -> icache_addr=0x800, Inst_Out=0x00500093, and a one-cycle Inst_Valid pulse.
- REQ-037: icache_ready=0 for 3 cycles in REQ -> icache_re=1 and fetch_stall=1 for those 3 cycles, then fetch_stall=0 for exactly one cycle.
- REQ-038: redirect in the WAIT cycle after accepting 0x2004, response 0xDEADBEEF later -> Inst_Out remains the previous value, Inst_Valid=0, and the next request uses the new PC_In=0x3000.
- REQ-039: redirect and icache_valid in the same cycle -> the data is dropped and the FSM goes straight to REQ.
- REQ-040: stall_in=1 for 4 cycles at delivery -> Inst_Out and Inst_Valid=1 held for 4 cycles, icache_re=0 throughout, and a new request on the cycle after stall_in drops.
- REQ-041: Reset asserted in WAIT, stale icache_valid next cycle -> Inst_Out=0x00000013 and Inst_Valid=0; with the macro defined, PC_In=0x2002 accepted -> Misaligned=1 until reset.
